// File: rtl/serial_disp_rx_if.sv
// serial_disp_rx_if: 3-wire display link pins plus the rebuilt-frame outputs of the receiver
interface serial_disp_rx_if #(parameter int WIDTH = 64);
  logic ser_clk;
  logic ser_do;
  logic ser_en;
  logic [WIDTH-1:0] data_out;
  logic data_valid;
  logic [7:0] frame_bits;
  logic frame_err;
  logic timeout_err;
  logic busy;
  logic [15:0] frame_count;
  modport master (
    output ser_clk, ser_do, ser_en,
    input data_out, data_valid, frame_bits, frame_err, timeout_err, busy, frame_count
  );
  modport slave (
    input ser_clk, ser_do, ser_en,
    output data_out, data_valid, frame_bits, frame_err, timeout_err, busy, frame_count
  );
endinterface

// File: rtl/serial_disp_rx.sv
// serial_disp_rx: oversampling receiver that rebuilds display-link frames as parallel words
module serial_disp_rx #(
  parameter int WIDTH = 64,
  parameter int MSB_FIRST = 1,
  parameter int SYNC_STAGES = 2,
  parameter int LATCH_POL = 1,
  parameter int TIMEOUT = 4096
) (
  input logic clk,
  input logic rst,
  serial_disp_rx_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [7:0] W8 = 8'(WIDTH);
  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);
  logic [SYNC_STAGES-1:0] sc, sd, se;
  logic hc, he, rise, lat, rise_q, lat_q, bit_q, tmo;
  logic [0:0] state;
  logic [15:0] tcnt, fcnt;
  logic [WIDTH-1:0] shreg, sh, dout;
  logic [7:0] bit_cnt, cnt, fbits;
  logic dv, ferr, terr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sc <= '0;
      sd <= '0;
      se <= '0;
      hc <= 1'b0;
      he <= 1'b0;
      rise_q <= 1'b0;
      lat_q <= 1'b0;
      bit_q <= 1'b0;
    end else begin
      sc <= {sc[SYNC_STAGES-2:0], bus.ser_clk};
      sd <= {sd[SYNC_STAGES-2:0], bus.ser_do};
      se <= {se[SYNC_STAGES-2:0], bus.ser_en};
      hc <= sc[SYNC_STAGES-1];
      he <= se[SYNC_STAGES-1];
      rise_q <= rise;
      lat_q <= lat;
      bit_q <= sd[SYNC_STAGES-1];
    end
  // Edge events are registered once so the pulse lands SYNC_STAGES+2 edges after the pin.
  always_comb begin
    rise = sc[SYNC_STAGES-1] & ~hc;
    lat = (LATCH_POL != 0) ? (se[SYNC_STAGES-1] & ~he) : (~se[SYNC_STAGES-1] & he);
    sh = !rise_q ? shreg : (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], bit_q} : {bit_q, shreg[WIDTH-1:1]};
    cnt = (rise_q && bit_cnt != 8'hFF) ? bit_cnt + 8'd1 : bit_cnt;
    tmo = (state == SHIFT) && !rise_q && !lat_q && (tcnt == TLAST);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tcnt <= '0;
      shreg <= '0;
      bit_cnt <= '0;
      dout <= '0;
      fbits <= '0;
      ferr <= 1'b0;
      dv <= 1'b0;
      terr <= 1'b0;
      fcnt <= '0;
    end else begin
      dv <= lat_q;
      terr <= tmo;
      tcnt <= (state == IDLE || rise_q || lat_q || tmo) ? '0 : tcnt + 16'd1;
      if (lat_q) begin
        fbits <= cnt;
        ferr <= cnt != W8;
        if (cnt != '0) dout <= sh;
        if (cnt == W8) fcnt <= fcnt + 16'd1;
        shreg <= '0;
        bit_cnt <= '0;
        state <= IDLE;
      end else if (tmo) begin
        shreg <= '0;
        bit_cnt <= '0;
        state <= IDLE;
      end else begin
        shreg <= sh;
        bit_cnt <= cnt;
        if (rise_q) state <= SHIFT;
      end
    end
  assign bus.data_out = dout;
  assign bus.data_valid = dv;
  assign bus.frame_bits = fbits;
  assign bus.frame_err = ferr;
  assign bus.timeout_err = terr;
  assign bus.busy = state == SHIFT;
  assign bus.frame_count = fcnt;
endmodule

// File: doc/serial_disp_rx.md
Name: serial_disp_rx

Overview:
- Receive end of the 3-wire serial link (shift clock, data, latch/enable) that the display block uses to drive the 7-segment and LED shift-register chains.
- Oversamples the three wires in the system clock domain and rebuilds each shifted frame as a parallel word.
- Flags malformed frames (wrong length, stalled link).
- Used for on-board loopback checking of the display path and as a bit-accurate monitor in system benches.

Parameters:
- WIDTH, 64, frame length in bits; legal range 2..255 (64 = 8 digits x 8 segments; use 16 for the LED chain).
- MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first received bit lands in data_out[0].
- SYNC_STAGES, 2, synchronizer depth on each input wire; legal range 2..4.
- LATCH_POL, 1, 1: frame latches on a rising edge of ser_en; 0: on a falling edge.
- TIMEOUT, 4096, clk cycles without a ser_clk rising edge while a frame is open before the partial frame is dropped; legal range 16..65535.

Ports:
- clk  in  1  system clock (25 MHz in the display domain).
- rst  in  1  asynchronous, active-high reset.
- ser_clk  in  1  link shift clock; asynchronous to clk.
- ser_do  in  1  link serial data; must be stable around ser_clk rising edges.
- ser_en  in  1  link latch strobe.
- data_out  out  WIDTH  last latched frame.
- data_valid  out  1  one-cycle pulse: frame latched (good or bad).
- frame_bits  out  8  number of bits counted in the last latched frame; saturates at 255.
- frame_err  out  1  qualified with data_valid: frame_bits != WIDTH.
- timeout_err  out  1  one-cycle pulse: open frame dropped by timeout.
- busy  out  1  high while a frame is open (state SHIFT).
- frame_count  out  16  count of data_valid pulses with frame_err=0; wraps from 65535 to 0.

Behaviour:
- Reset (async assert, sync release): all outputs 0; synchronizer and edge flops 0; shift register 0; state IDLE; bit and timeout counters 0.
- Input path:
  - Each wire passes through SYNC_STAGES flops, then one history flop.
  - Edge = synced value differs from history in the relevant direction.
  - ser_do is sampled from its own synced stage in the same cycle a ser_clk rising edge is detected.
  - Link timing requirement: ser_clk high and low each >= SYNC_STAGES+1 clk cycles; ser_do setup/hold >= SYNC_STAGES+1 clk cycles around the ser_clk rising edge. Behaviour outside these limits is undefined but must not lock up.
- Shift:
  - On each ser_clk rising edge, shreg shifts in one bit.
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], bit}. MSB_FIRST=0: shreg <= {bit, shreg[WIDTH-1:1]}.
  - bit_cnt increments and saturates at 255.
  - More than WIDTH bits: shreg keeps the last WIDTH bits received.
- State machine:
  - IDLE -> SHIFT on the first ser_clk rising edge.
  - SHIFT -> IDLE on a latch edge, or when the timeout counter reaches TIMEOUT-1.
  - The timeout counter clears on every ser_clk edge and is held at 0 in IDLE.
- Latch edge:
  - Next cycle: data_valid=1, frame_bits=bit_cnt (including a bit shifted in the same cycle), frame_err=(bit_cnt!=WIDTH).
  - data_out <= shreg only if bit_cnt>0; a latch with 0 bits pulses data_valid with frame_bits=0 and frame_err=1, and data_out holds.
  - Afterwards shreg and bit_cnt clear; frame_count increments when frame_err=0.
- Latency: latch edge on the pin to data_valid high = exactly SYNC_STAGES+2 clk edges.
- Simultaneous ser_clk rise and latch edge in the same cycle: the bit is shifted in first and included in the latched frame.
- Timeout: shreg and bit_cnt clear, timeout_err pulses once, data_out holds, no data_valid.
- data_valid and timeout_err are never high in the same cycle.
- Reset mid-frame: the frame is discarded and nothing is emitted.

Test Plan:
- WIDTH=64, MSB_FIRST=1: shift 64'hDEAD_BEEF_0123_4567 MSB first, then latch -> one data_valid pulse, data_out=64'hDEADBEEF01234567, frame_bits=64, frame_err=0, frame_count=1; pulse occurs SYNC_STAGES+2 clks after the latch pin edge.
- WIDTH=16, MSB_FIRST=0: send 16'hA5C3 LSB first, then latch -> data_out=16'hA5C3, frame_err=0; then send 15 bits and latch -> frame_bits=15, frame_err=1, frame_count still 1.
- WIDTH=16: send 20 bits (4'hF then 16'h1234), then latch -> data_out=16'h1234, frame_bits=20, frame_err=1.
- Send 10 bits, then idle for TIMEOUT cycles -> timeout_err pulses once, busy falls, no data_valid, data_out unchanged; a following good frame latches correctly.
- Latch with no bits -> data_valid=1, frame_bits=0, frame_err=1, data_out unchanged. Last ser_clk rise coincident with latch -> that bit is included and frame_bits=WIDTH.
- Assert rst after 30 bits of a 64-bit frame -> all outputs 0; after release, a full frame 64'h0000_0000_FFFF_FFFF latches correctly with frame_count=1.
